// File: rtl/regfile_write_queue_pkg.sv
// Shared writeback definitions for the integer register-file write path.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WQ_DEPTH   = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  function automatic wb_entry_t make_entry(input logic [REG_ADDR_W-1:0] rd,
                                           input logic [XLEN-1:0]       data);
    wb_entry_t e;
    e.rd   = rd;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/regfile_write_queue_if.sv
// Producer/consumer bundle of the writeback queue: ALU and load pushes, drain port, bypass lookups.
interface regfile_write_queue_if
  import rv_pkg::*;
#(
  parameter int WIDTH      = XLEN,
  parameter int ADDR_LINES = REG_ADDR_W,
  parameter int DEPTH      = WQ_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  alu_valid;
  logic [ADDR_LINES-1:0] alu_rd;
  logic [WIDTH-1:0]      alu_data;
  logic                  ld_valid;
  logic [ADDR_LINES-1:0] ld_rd;
  logic [WIDTH-1:0]      ld_data;
  logic                  in_ready;
  logic                  WE3;
  logic [ADDR_LINES-1:0] A3;
  logic [WIDTH-1:0]      WD3;
  logic [ADDR_LINES-1:0] byp_a1;
  logic [ADDR_LINES-1:0] byp_a2;
  logic                  byp_hit1;
  logic                  byp_hit2;
  logic [WIDTH-1:0]      byp_data1;
  logic [WIDTH-1:0]      byp_data2;
  logic [CW-1:0]         count;
  logic                  overflow;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, byp_a1, byp_a2,
    input  in_ready, WE3, A3, WD3, byp_hit1, byp_hit2, byp_data1, byp_data2, count, overflow
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, byp_a1, byp_a2,
    output in_ready, WE3, A3, WD3, byp_hit1, byp_hit2, byp_data1, byp_data2, count, overflow
  );

endinterface

// File: rtl/regfile_write_queue_fifo.sv
// Circular buffer with two write ports (wr0 older than wr1) and one pop per cycle.
// Exposes every slot in age order (offset 0 = head) for the bypass search.
module regfile_wq_fifo #(
  parameter int DW    = 37,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                      clk,
  input  logic                      areset,
  input  logic                      wr0_en,
  input  logic [DW-1:0]             wr0_data,
  input  logic                      wr1_en,
  input  logic [DW-1:0]             wr1_data,
  input  logic                      rd_en,
  output logic [DW-1:0]             head_data,
  output logic [CW-1:0]             count,
  output logic [DEPTH-1:0]          ord_valid,
  output logic [DEPTH-1:0][DW-1:0]  ord_data
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic [PW-1:0] wr1_addr;

  // The second write lands one past the first when both are present.
  assign wr1_addr   = tail_reg + PW'(wr0_en);
  assign head_next  = head_reg + PW'(rd_en);
  assign tail_next  = tail_reg + PW'(wr0_en) + PW'(wr1_en);
  assign count_next = count_reg + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr0_en) mem[tail_reg] <= wr0_data;
    if (wr1_en) mem[wr1_addr] <= wr1_data;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_order
      assign ord_data[gi]  = mem[head_reg + PW'(gi)];
      assign ord_valid[gi] = (CW'(gi) < count_reg);
    end
  endgenerate

  assign head_data = mem[head_reg];
  assign count     = count_reg;

endmodule

// File: rtl/regfile_write_queue.sv
// Writeback queue: merges ALU and load results, drains one per cycle onto WE3/A3/WD3,
// and answers two bypass lookups from the pending entries.
module regfile_write_queue
  import rv_pkg::*;
#(
  parameter int WIDTH      = XLEN,
  parameter int ADDR_LINES = REG_ADDR_W,
  parameter int DEPTH      = WQ_DEPTH
) (
  input logic                  clk,
  input logic                  areset,
  regfile_write_queue_if.slave bus
);

  localparam int DW = ADDR_LINES + WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;

  logic                     ld_push, alu_push;
  logic                     ld_take, alu_take;
  logic                     pop;
  logic [CW-1:0]            count;
  logic [CW-1:0]            free_slots;
  logic                     wr0_en, wr1_en;
  logic [DW-1:0]            wr0_data, wr1_data, head_data;
  logic [DEPTH-1:0]         ord_valid;
  logic [DEPTH-1:0][DW-1:0] ord_data;
  logic                     overflow_reg, overflow_next;
  logic [DEPTH-1:0]         match1, match2;
  logic                     hit1, hit2;
  logic [WIDTH-1:0]         data1, data2;

  // Writes to x0 are architecturally void, so they never occupy a slot.
  assign ld_push  = bus.ld_valid  && (bus.ld_rd  != '0);
  assign alu_push = bus.alu_valid && (bus.alu_rd != '0);
  assign pop      = (count != '0);

  // The slot freed by this cycle's pop is usable by this cycle's pushes.
  assign free_slots = CW'(DEPTH) - count + CW'(pop);
  assign ld_take    = ld_push  && (free_slots >= CW'(1));
  assign alu_take   = alu_push && (free_slots >= (ld_take ? CW'(2) : CW'(1)));

  // Load is the older of a simultaneous pair; a lone push always uses port 0.
  assign wr0_en   = ld_take || alu_take;
  assign wr0_data = ld_take ? {bus.ld_rd, bus.ld_data} : {bus.alu_rd, bus.alu_data};
  assign wr1_en   = ld_take && alu_take;
  assign wr1_data = {bus.alu_rd, bus.alu_data};

  assign overflow_next = overflow_reg || (ld_push && !ld_take) || (alu_push && !alu_take);

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) overflow_reg <= 1'b0;
    else         overflow_reg <= overflow_next;
  end

  regfile_wq_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .areset    (areset),
    .wr0_en    (wr0_en),
    .wr0_data  (wr0_data),
    .wr1_en    (wr1_en),
    .wr1_data  (wr1_data),
    .rd_en     (pop),
    .head_data (head_data),
    .count     (count),
    .ord_valid (ord_valid),
    .ord_data  (ord_data)
  );

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match1[gi] = ord_valid[gi] && (ord_data[gi][DW-1:WIDTH] == bus.byp_a1);
      assign match2[gi] = ord_valid[gi] && (ord_data[gi][DW-1:WIDTH] == bus.byp_a2);
    end
  endgenerate

  // Scan head to tail so the youngest matching entry wins.
  always_comb begin
    hit1  = 1'b0;
    hit2  = 1'b0;
    data1 = '0;
    data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match1[k]) begin
        hit1  = 1'b1;
        data1 = ord_data[k][WIDTH-1:0];
      end
      if (match2[k]) begin
        hit2  = 1'b1;
        data2 = ord_data[k][WIDTH-1:0];
      end
    end
    if (bus.byp_a1 == '0) begin
      hit1  = 1'b0;
      data1 = '0;
    end
    if (bus.byp_a2 == '0) begin
      hit2  = 1'b0;
      data2 = '0;
    end
  end

  assign bus.byp_hit1  = hit1;
  assign bus.byp_hit2  = hit2;
  assign bus.byp_data1 = data1;
  assign bus.byp_data2 = data2;

  assign bus.WE3      = pop;
  assign bus.A3       = pop ? head_data[DW-1:WIDTH] : '0;
  assign bus.WD3      = pop ? head_data[WIDTH-1:0]  : '0;
  assign bus.in_ready = (count <= CW'(DEPTH - 2));
  assign bus.count    = count;
  assign bus.overflow = overflow_reg;

endmodule
